dot_product_fp16_stream: RTL and testbench
==========================================

// Module: dot_product_fp16_stream
// PURPOSE
// Streaming fp16 dot-product engine around mlp_stack: accepts K*B operand pairs per beat
// with valid/ready, generates first/last from a beat counter, and buffers finished sums
// in an output FIFO with downstream backpressure. Credit-based admission: mlp_stack never stalls.
// PARAMETERS
// K           4    number of MLPs in mlp_stack (>=2)
// B           2    parallel fp16 multiplies per MLP
// FP          16   fp width (fp16, E=5)
// VEC_LEN     64   elements per dot product; multiple of K*B; BEATS = VEC_LEN/(K*B) >= 1
// MLP_LAT     8    mlp_stack latency, reg_last -> valid, in cycles
// OUT_DEPTH   8    output FIFO depth, power of 2, >=2
// PORTS
// i_clk        in   1         clock
// i_reset      in   1         async reset, active-high
// i_a          in   K*B*FP    operand A beat (fp16 lanes)
// i_b          in   K*B*FP    operand B beat (fp16 lanes)
// i_valid      in   1         beat valid
// o_ready      out  1         beat accepted when i_valid & o_ready
// o_sum        out  FP        dot-product result (fp16)
// o_valid      out  1         o_sum valid
// i_ready      in   1         downstream ready; pop when o_valid & i_ready
// o_busy       out  1         vector in progress, or results in flight/FIFO
// o_done_cnt   out  16        results popped since reset, wraps 16'hFFFF->0
// BEHAVIOUR
// - One clock, i_clk. Reset is asynchronous and active-high on i_reset.
// - Reset: o_ready=0, o_valid=0, o_sum=0, o_busy=0, o_done_cnt=0; FIFO empty; beat_cnt=0;
//   credits=OUT_DEPTH; flush counter loaded with MLP_LAT+2.
// - FSM: FLUSH -> IDLE -> ACCUM -> IDLE.
//   FLUSH: o_ready=0; mlp_stack valid ignored; goes to IDLE when flush counter hits 0.
//   This discards partial sums still in flight across a reset.
// - IDLE: o_ready = (credits>0). An accepted beat reserves a credit (credits-1) and drives first=1.
//   If BEATS==1 it also drives last=1 and stays in IDLE. Otherwise beat_cnt=1 -> ACCUM.
// - ACCUM: o_ready=1 unconditionally, since the slot is already reserved.
//   Each accepted beat increments beat_cnt. The beat with beat_cnt==BEATS-1 drives last=1,
//   clears beat_cnt and goes to IDLE.
// - Gaps (i_valid=0): lanes driven to +0.0, first=last=0. The accumulator adds 0,
//   so the result is unchanged.
// - Input regs (a, b, first, last) and output regs (sum, valid) around mlp_stack are
//   kept unretimed. mlp_stack valid (post FLUSH) writes its sum into the FIFO.
// - Latency with the FIFO empty and i_ready=1: last beat accepted at cycle T ->
//   o_valid=1 at T+MLP_LAT+3. o_sum is stable while o_valid & !i_ready.
// - Credit on pop: credits+1. A reserve and a pop in the same cycle leave credits unchanged.
//   Invariant: credits + in_flight + fifo_count == OUT_DEPTH. The FIFO can never overflow.
//   Assert this in simulation.
// - Full: with credits==0 in IDLE, o_ready=0 and new vectors stall. A vector already
//   in ACCUM completes.
// - Results leave in acceptance order. Empty FIFO -> o_valid=0.
// - o_busy = (state!=IDLE) | (credits!=OUT_DEPTH) | (state==FLUSH).
// - Reset mid-vector or with results queued: partial and queued results are dropped;
//   no o_valid until a new full vector completes.
// TESTING
// 1. VEC_LEN=64, 8 beats of all lanes a=16'h3C00, b=16'h3C00, i_ready=1 ->
//    one o_valid pulse, o_sum=16'h5400 (64.0), MLP_LAT+3 cycles after the last beat.
// 2. Same vector with a=16'h4000 (2.0), b=16'h3800 (0.5), 1-3 random i_valid=0 gaps
//    between beats -> o_sum=16'h5400. o_ready stays 1 throughout ACCUM.
// 3. i_ready=0, offer 10 back-to-back vectors (1.0*1.0) -> exactly 8 vectors accepted,
//    o_ready=0 at the 9th first beat. Raise i_ready -> 8 results of 16'h5400 in order,
//    o_done_cnt=8. The 9th vector is then accepted.
// 4. Vectors with distinct results (lane value k*1.0 for vector k=1..4, b=1.0) with
//    i_ready toggling 1010... -> outputs 64*k in order, no loss or duplication;
//    credit invariant assertion never fires.
// 5. Assert i_reset for 1 cycle at beat 4 of a vector, with 2 results queued ->
//    o_valid=0, o_done_cnt=0, o_ready=0 for MLP_LAT+2 cycles. A next full vector of
//    1.0*1.0 yields exactly 16'h5400.

Source files
------------

// File: rtl/dot_product_fp16_stream_if.sv
// Beat and result stream bundle for dot_product_fp16_stream.
// The engine uses the slave view; the producer/consumer uses the master view.
interface dot_product_fp16_stream_if #(
    parameter int K  = 4,
    parameter int B  = 2,
    parameter int FP = 16
);
    logic [K*B*FP-1:0] i_a;
    logic [K*B*FP-1:0] i_b;
    logic              i_valid;
    logic              o_ready;
    logic [FP-1:0]     o_sum;
    logic              o_valid;
    logic              i_ready;
    logic              o_busy;
    logic [15:0]       o_done_cnt;

    modport master (
        output i_a, i_b, i_valid, i_ready,
        input  o_ready, o_sum, o_valid, o_busy, o_done_cnt
    );

    modport slave (
        input  i_a, i_b, i_valid, i_ready,
        output o_ready, o_sum, o_valid, o_busy, o_done_cnt
    );
endinterface

// File: rtl/dot_product_fp16_stream.sv
// Streaming fp16 dot-product engine: K*B lane multiply, beat accumulation,
// fixed-latency result pipe and a credit-protected output FIFO.
module dot_product_fp16_stream #(
    parameter int K         = 4,
    parameter int B         = 2,
    parameter int FP        = 16,
    parameter int VEC_LEN   = 64,
    parameter int MLP_LAT   = 8,
    parameter int OUT_DEPTH = 8
) (
    input logic i_clk,
    input logic i_reset,
    dot_product_fp16_stream_if.slave bus
);
    localparam int LANES = K * B;
    localparam int LW    = LANES * FP;
    localparam int BEATS = VEC_LEN / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(OUT_DEPTH);
    localparam int CRW   = AW + 1;
    localparam int FLW   = $clog2(MLP_LAT + 3);

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_ACCUM} state_t;

    // fp16 multiply: subnormals flush to zero, rounds toward zero.
    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic              s;
        logic [21:0]       p;
        logic signed [7:0] e;
        logic [9:0]        f;
        s = a[15] ^ b[15];
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        if (p[21]) begin
            f = p[20:11];
            e = e + 8'sd1;
        end else begin
            f = p[19:10];
        end
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0 || e <= 8'sd0) return {s, 15'd0};
        if (e >= 8'sd31) return {s, 5'h1f, 10'd0};
        return {s, e[4:0], f};
    endfunction

    // fp16 add: subnormals flush to zero, rounds toward zero.
    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0]       x;
        logic [15:0]       y;
        logic [4:0]        d;
        logic [14:0]       mx;
        logic [14:0]       my;
        logic [14:0]       m;
        logic signed [6:0] e;
        if (a[14:10] == 5'd0) return b;
        if (b[14:10] == 5'd0) return a;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[14:10] - y[14:10];
        mx = {2'b01, x[9:0], 3'b000};
        my = {2'b01, y[9:0], 3'b000} >> d;
        e  = {2'b00, x[14:10]};
        if (x[15] == y[15]) begin
            m = mx + my;
            if (m[14]) begin
                m = m >> 1;
                e = e + 7'sd1;
            end
        end else begin
            m = mx - my;
            if (m == 15'd0) return 16'h0000;
            for (int i = 0; i < 13; i++) begin
                if (!m[13]) begin
                    m = m << 1;
                    e = e - 7'sd1;
                end
            end
        end
        if (e <= 7'sd0) return {x[15], 15'd0};
        if (e >= 7'sd31) return {x[15], 5'h1f, 10'd0};
        return {x[15], e[4:0], m[12:3]};
    endfunction

    state_t           state_q, state_d;
    logic [FLW-1:0]   flush_q, flush_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [CRW-1:0]   credits_q, credits_d;
    logic [CRW-1:0]   inflight_q, inflight_d;
    logic [15:0]      done_q, done_d;
    logic             ready;
    logic             accept;
    logic             first;
    logic             last;
    logic             reserve;
    logic             pop;
    logic             fifo_wr;

    logic [LW-1:0]    in_a_q, in_a_d;
    logic [LW-1:0]    in_b_q, in_b_d;
    logic             in_first_q, in_first_d;
    logic             in_last_q, in_last_d;
    logic [FP-1:0]    acc_q, acc_d;
    logic [FP-1:0]    part;
    logic [FP-1:0]    bsum;
    logic [FP-1:0]    dly_sum_q [MLP_LAT];
    logic [FP-1:0]    dly_sum_d [MLP_LAT];
    logic [MLP_LAT-1:0] dly_vld_q, dly_vld_d;
    logic [FP-1:0]    out_sum_q, out_sum_d;
    logic             out_vld_q, out_vld_d;

    logic [FP-1:0]    mem_q [OUT_DEPTH];
    logic [FP-1:0]    mem_d [OUT_DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CRW-1:0]   cnt_q, cnt_d;
    logic             fifo_valid;

    assign fifo_valid     = (cnt_q != '0);
    assign pop            = fifo_valid & bus.i_ready;
    assign fifo_wr        = out_vld_q & (state_q != S_FLUSH);
    assign bus.o_ready    = ready;
    assign bus.o_valid    = fifo_valid;
    assign bus.o_sum      = fifo_valid ? mem_q[rd_q] : '0;
    assign bus.o_busy     = (state_q != S_IDLE) | (credits_q != CRW'(OUT_DEPTH));
    assign bus.o_done_cnt = done_q;

    // Admission FSM, beat counter, credit and pop bookkeeping.
    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        beat_d     = beat_q;
        ready      = 1'b0;
        accept     = 1'b0;
        first      = 1'b0;
        last       = 1'b0;
        reserve    = 1'b0;
        credits_d  = credits_q;
        inflight_d = inflight_q;
        done_d     = done_q + 16'(pop);
        unique case (state_q)
            S_FLUSH: begin
                flush_d = flush_q - FLW'(1);
                if (flush_q == FLW'(1)) state_d = S_IDLE;
            end
            S_IDLE: begin
                ready  = (credits_q != '0);
                accept = bus.i_valid & ready;
                if (accept) begin
                    reserve = 1'b1;
                    first   = 1'b1;
                    if (BEATS == 1) begin
                        last = 1'b1;
                    end else begin
                        beat_d  = CW'(1);
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                ready  = 1'b1;
                accept = bus.i_valid;
                if (accept) begin
                    beat_d = beat_q + CW'(1);
                    if (beat_q == CW'(BEATS - 1)) begin
                        last    = 1'b1;
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_FLUSH;
        endcase
        unique case ({reserve, pop})
            2'b10:   credits_d = credits_q - CRW'(1);
            2'b01:   credits_d = credits_q + CRW'(1);
            default: credits_d = credits_q;
        endcase
        unique case ({reserve, fifo_wr})
            2'b10:   inflight_d = inflight_q + CRW'(1);
            2'b01:   inflight_d = inflight_q - CRW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_FLUSH;
            flush_q    <= FLW'(MLP_LAT + 2);
            beat_q     <= '0;
            credits_q  <= CRW'(OUT_DEPTH);
            inflight_q <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            beat_q     <= beat_d;
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // MLP stack: input regs, lane products, beat accumulation, latency pipe.
    always_comb begin
        in_a_d     = accept ? bus.i_a : '0;
        in_b_d     = accept ? bus.i_b : '0;
        in_first_d = first;
        in_last_d  = last;
        bsum       = '0;
        part       = '0;
        for (int k = 0; k < K; k++) begin
            part = '0;
            for (int j = 0; j < B; j++) begin
                part = fp_add(part, fp_mul(in_a_q[(k*B+j)*FP +: FP],
                                           in_b_q[(k*B+j)*FP +: FP]));
            end
            bsum = fp_add(bsum, part);
        end
        acc_d        = in_first_q ? bsum : fp_add(acc_q, bsum);
        dly_sum_d[0] = acc_d;
        dly_vld_d[0] = in_last_q;
        for (int i = 1; i < MLP_LAT; i++) begin
            dly_sum_d[i] = dly_sum_q[i-1];
            dly_vld_d[i] = dly_vld_q[i-1];
        end
        out_sum_d = dly_sum_q[MLP_LAT-1];
        out_vld_d = dly_vld_q[MLP_LAT-1];
    end

    // MLP stack registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            in_a_q     <= '0;
            in_b_q     <= '0;
            in_first_q <= 1'b0;
            in_last_q  <= 1'b0;
            acc_q      <= '0;
            dly_vld_q  <= '0;
            out_sum_q  <= '0;
            out_vld_q  <= 1'b0;
            for (int i = 0; i < MLP_LAT; i++) dly_sum_q[i] <= '0;
        end else begin
            in_a_q     <= in_a_d;
            in_b_q     <= in_b_d;
            in_first_q <= in_first_d;
            in_last_q  <= in_last_d;
            acc_q      <= acc_d;
            dly_vld_q  <= dly_vld_d;
            out_sum_q  <= out_sum_d;
            out_vld_q  <= out_vld_d;
            for (int i = 0; i < MLP_LAT; i++) dly_sum_q[i] <= dly_sum_d[i];
        end
    end

    // Output FIFO next state; credits guarantee a free slot on every write.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (fifo_wr) begin
            mem_d[wr_q] = out_sum_q;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        unique case ({fifo_wr, pop})
            2'b10:   cnt_d = cnt_q + CRW'(1);
            2'b01:   cnt_d = cnt_q - CRW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Output FIFO registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    logic [CRW+1:0] inv_sum;
    assign inv_sum = (CRW+2)'(credits_q) + (CRW+2)'(inflight_q) + (CRW+2)'(cnt_q);

    a_credit_inv: assert property (
        @(posedge i_clk) disable iff (i_reset) inv_sum == (CRW+2)'(OUT_DEPTH)
    );
endmodule

// File: tb/tb_dot_product_fp16_stream.sv
// Scoreboard bench for dot_product_fp16_stream: directed fp16 vectors,
// expected sums queued at issue and popped by an output monitor.
module tb_dot_product_fp16_stream;
    localparam int K         = 4;
    localparam int B         = 2;
    localparam int FP        = 16;
    localparam int VEC_LEN   = 64;
    localparam int MLP_LAT   = 8;
    localparam int OUT_DEPTH = 8;
    localparam int LANES     = K * B;
    localparam int BEATS     = VEC_LEN / LANES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_product_fp16_stream_if #(.K(K), .B(B), .FP(FP)) bus ();

    dot_product_fp16_stream #(
        .K(K), .B(B), .FP(FP), .VEC_LEN(VEC_LEN),
        .MLP_LAT(MLP_LAT), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int npop     = 0;
    logic [15:0] exp_q [$];
    bit   rdy_toggle = 1'b0;
    logic rdy_level  = 1'b0;
    logic [15:0] kval [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    logic [15:0] kexp [4] = '{16'h5400, 16'h5800, 16'h5A00, 16'h5C00};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready driver: held level or 1010 toggle.
    initial begin
        bus.i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_ready = rdy_toggle ? ~bus.i_ready : rdy_level;
        end
    end

    // Output monitor: every pop is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.o_valid && bus.i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got %h, expected none", bus.o_sum);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (bus.o_sum !== e) begin
                        failures++;
                        $display("FAIL result: got %h, expected %h", bus.o_sum, e);
                    end
                end
                npop++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] av, input logic [15:0] bv,
                             input int limit, output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        bus.i_a     = {LANES{av}};
        bus.i_b     = {LANES{bv}};
        bus.i_valid = 1'b1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
            step();
        end
        if (ok) step();
        bus.i_valid = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
    endtask

    task automatic gap();
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("accum_ready", bus.o_ready, 1);
        step();
    endtask

    task automatic send_vec(input logic [15:0] av, input logic [15:0] bv,
                            input int maxgap, input logic [15:0] expv, output int t_last);
        bit ok;
        bit all_ok;
        int t;
        all_ok = 1'b1;
        t = 0;
        for (int i = 0; i < BEATS; i++) begin
            if (i > 0 && maxgap > 0) repeat ($urandom_range(1, maxgap)) gap();
            send_beat(av, bv, (i == 0) ? 80 : 1, ok, t);
            if (!ok) all_ok = 1'b0;
        end
        chk("vec_accept", all_ok, 1);
        if (all_ok) exp_q.push_back(expv);
        t_last = t;
    endtask

    task automatic drain(input int limit);
        for (int n = 0; n < limit && exp_q.size() != 0; n++) step();
        chk("drain_empty", exp_q.size(), 0);
        repeat (3) step();
    endtask

    initial begin
        int  t;
        int  n;
        int  base;
        bit  ok;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_sum", bus.o_sum, 0);
        chk("rst_done", bus.o_done_cnt, 0);
        step();
        rst = 1'b0;

        // 1: ones vector, latency
        rdy_level = 1'b1;
        send_vec(16'h3C00, 16'h3C00, 0, 16'h5400, t);
        chk("busy_inflight", bus.o_busy, 1);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.o_valid) break;
        end
        chk("latency", cyc - t, MLP_LAT + 3);
        step();
        drain(100);
        chk("done_t1", bus.o_done_cnt, 1);
        chk("idle_busy", bus.o_busy, 0);

        // 2: 2.0*0.5 with random gaps
        send_vec(16'h4000, 16'h3800, 3, 16'h5400, t);
        drain(100);

        // 3: backpressure fills all credits
        rdy_level = 1'b0;
        step();
        do_reset(2);
        base = npop;
        for (int v = 0; v < OUT_DEPTH; v++) send_vec(16'h3C00, 16'h3C00, 0, 16'h5400, t);
        repeat (15) step();
        send_beat(16'h3C00, 16'h3C00, 20, ok, t);
        chk("full_stall", ok, 0);
        @(negedge clk);
        chk("hold_valid", bus.o_valid, 1);
        chk("fifo_head", bus.o_sum, 16'h5400);
        step();
        rdy_level = 1'b1;
        fork
            begin
                send_vec(16'h3C00, 16'h3C00, 0, 16'h5400, t);
                send_vec(16'h3C00, 16'h3C00, 0, 16'h5400, t);
            end
            begin
                for (int m = 0; m < 200; m++) begin
                    @(negedge clk);
                    #1;
                    if (npop - base >= OUT_DEPTH) break;
                end
                step();
                @(negedge clk);
                chk("done_after_8", bus.o_done_cnt, 8);
            end
        join
        drain(200);
        chk("done_t3", bus.o_done_cnt, 10);

        // 4: distinct results, ready toggling
        do_reset(2);
        rdy_toggle = 1'b1;
        for (int k = 0; k < 4; k++) send_vec(kval[k], 16'h3C00, 0, kexp[k], t);
        drain(300);
        rdy_toggle = 1'b0;
        rdy_level  = 1'b1;
        repeat (3) step();
        chk("done_t4", bus.o_done_cnt, 4);

        // 5: reset mid-vector with two queued results
        rdy_level = 1'b0;
        step();
        do_reset(2);
        send_vec(16'h3C00, 16'h3C00, 0, 16'h5400, t);
        send_vec(16'h3C00, 16'h3C00, 0, 16'h5400, t);
        repeat (16) step();
        @(negedge clk);
        chk("queued_valid", bus.o_valid, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            send_beat(16'h3C00, 16'h3C00, (i == 0) ? 20 : 1, ok, t);
            chk("partial_beat", ok, 1);
        end
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        for (int i = 0; i < MLP_LAT + 2; i++) begin
            @(negedge clk);
            chk("flush_ready", bus.o_ready, 0);
            chk("flush_valid", bus.o_valid, 0);
            chk("flush_done", bus.o_done_cnt, 0);
            step();
        end
        rdy_level = 1'b1;
        send_vec(16'h3C00, 16'h3C00, 0, 16'h5400, t);
        drain(100);
        repeat (20) step();
        chk("done_t5", bus.o_done_cnt, 1);
        chk("end_busy", bus.o_busy, 0);
        chk("end_valid", bus.o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
